agc_stim_sequencer: RTL
=======================

AGC_STIM_SEQUENCER -- requirements
Module: agc_stim_sequencer

Interface
REQ-001 Parameter N_CH, default 16, number of driven stimulus channels.
REQ-002 Parameter DEPTH, default 16, number of script entries (power of two, minimum 2).
REQ-003 Parameter WAIT_W, default 24, width of the per-entry hold count.
REQ-004 SIM_CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SIM_RST  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  script write strobe.
REQ-007 wr_addr  input  clog2(DEPTH)  script entry index to write.
REQ-008 wr_wait  input  WAIT_W  hold count for the entry.
REQ-009 wr_level  input  N_CH  output levels for the entry.
REQ-010 wr_last  input  1  marks the entry as end of script.
REQ-011 start  input  1  level-sampled run request.
REQ-012 abort  input  1  level-sampled stop request.
REQ-013 loop  input  1  restart from entry 0 after the last entry; sampled at each end-of-script.
REQ-014 ch_out  output  N_CH  registered stimulus levels (e.g. MSTRT, MSTP, MDT bits).
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  high while in DONE.
REQ-017 step_idx  output  clog2(DEPTH)  index of the entry currently applied.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE with start=1, abort=0: at the next edge, ch_out<=level[0], cnt<=wait[0], step_idx<=0, state<=RUN.
REQ-020 RUN with cnt!=0: cnt decrements by 1; ch_out and step_idx are held.
REQ-021 RUN with cnt==0 and step_idx not terminal: apply entry step_idx+1 (level, wait) at the same edge.
REQ-022 An entry is terminal if its last=1 or step_idx==DEPTH-1; no index wrap occurs except through loop.
REQ-023 RUN with cnt==0 on a terminal entry: loop=1 applies entry 0 and stays in RUN; loop=0 goes to DONE with ch_out held.
REQ-024 Each entry drives ch_out for exactly wait+1 cycles; wait=0 gives a one-cycle pulse.
REQ-025 DONE with start=1 restarts exactly as in REQ-019; with start=0 it holds.
REQ-026 abort=1 in any state: next edge ch_out<=0, cnt<=0, step_idx<=0, state<=IDLE; abort wins over a simultaneous start.
REQ-027 Writes are accepted in every state; an entry loaded at the same edge as a write to it SHALL use the pre-write contents.
REQ-028 Hold count is unsigned and saturates at no point; cnt never underflows below 0.
REQ-029 Latency from start sampled high to first ch_out change SHALL be one cycle.

Reset
REQ-030 SIM_RST high SHALL immediately force ch_out=0, busy=0, done=0, step_idx=0, cnt=0, state=IDLE.
REQ-031 SIM_RST SHALL clear every script entry to wait=0, level=0, last=1.
REQ-032 Reset asserted mid-RUN SHALL discard progress; the first edge after deassertion observes IDLE.

Structure
REQ-033 Package agc_sim_pkg SHALL hold the state enumeration and entry field-width helper constants.
REQ-034 Script storage SHALL be a sub-module agc_seq_mem (one write port, one asynchronous read port, reset-cleared).
REQ-035 FSM, counter and output register SHALL reside in agc_stim_sequencer.

Verification
REQ-036 Script {wait=9,level=0x0000}, {wait=99,level=0x0001,last=1}, loop=0, start pulse -> ch_out=0 for 10 cycles, bit0 high for 100 cycles, then done=1 with ch_out=0x0001.
REQ-037 Same script, loop=1 -> ch_out alternates 10 cycles 0x0000 / 100 cycles 0x0001 indefinitely; done stays 0.
REQ-038 All DEPTH entries wait=0, level=index, no last flags -> ch_out counts 0..DEPTH-1 one per cycle, then DONE.
REQ-039 abort asserted together with start while in RUN at step 1 -> next cycle ch_out=0, state IDLE, busy=0.
REQ-040 SIM_RST pulsed mid-RUN -> outputs 0 immediately, script reads back wait=0/level=0/last=1, a new start yields a one-cycle 0x0000 then DONE.
REQ-041 Write to entry 1 during the edge on which entry 1 loads -> old level appears; rewritten level appears on the next loop pass.

Source files
------------

// File: rtl/agc_sim_pkg.sv
// Shared types and helpers for the AGC stimulus sequencer.
package agc_sim_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    // A script entry is stored packed as {last, level, wait}
    localparam int unsigned LastFieldW = 1;

    function automatic int unsigned entry_width(input int unsigned n_ch,
                                                input int unsigned wait_w);
        return n_ch + wait_w + LastFieldW;
    endfunction

endpackage

// File: rtl/agc_seq_mem.sv
// Script storage: one synchronous write port, one asynchronous read port.
// Reset restores every entry to a one-cycle, all-zero, terminal step.
module agc_seq_mem
    import agc_sim_pkg::*;
#(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WAIT_W = 24,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WAIT_W-1:0] wr_wait_i,
    input  logic [N_CH-1:0]   wr_level_i,
    input  logic              wr_last_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WAIT_W-1:0] rd_wait_o,
    output logic [N_CH-1:0]   rd_level_o,
    output logic              rd_last_o
);

    localparam int unsigned EntryW = entry_width(N_CH, WAIT_W);
    localparam logic [EntryW-1:0] ResetEntry = {1'b1, {(N_CH + WAIT_W){1'b0}}};

    logic [EntryW-1:0] mem_q [DEPTH];

    // Entry storage with reset-clear and a single write port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ResetEntry;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_last_i, wr_level_i, wr_wait_i};
        end
    end

    // Asynchronous read returns pre-write contents during a same-edge write
    assign {rd_last_o, rd_level_o, rd_wait_o} = mem_q[rd_addr_i];

endmodule

// File: rtl/agc_stim_sequencer.sv
// Scripted stimulus sequencer: plays a table of {level, hold} entries onto
// ch_out, optionally looping, with start/abort control.
module agc_stim_sequencer
    import agc_sim_pkg::*;
#(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WAIT_W = 24,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WAIT_W-1:0] wr_wait,
    input  logic [N_CH-1:0]   wr_level,
    input  logic              wr_last,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    output logic [N_CH-1:0]   ch_out,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);

    seq_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [N_CH-1:0]   ch_q, ch_d;
    logic              last_q, last_d;   // last flag of the entry being applied

    logic [AW-1:0]     rd_addr;
    logic [WAIT_W-1:0] rd_wait;
    logic [N_CH-1:0]   rd_level;
    logic              rd_last;
    logic              terminal;

    agc_seq_mem #(
        .N_CH   (N_CH),
        .DEPTH  (DEPTH),
        .WAIT_W (WAIT_W)
    ) u_mem (
        .clk_i      (SIM_CLK),
        .rst_i      (SIM_RST),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_wait_i  (wr_wait),
        .wr_level_i (wr_level),
        .wr_last_i  (wr_last),
        .rd_addr_i  (rd_addr),
        .rd_wait_o  (rd_wait),
        .rd_level_o (rd_level),
        .rd_last_o  (rd_last)
    );

    assign terminal = last_q | (idx_q == AW'(DEPTH - 1));

    // Next entry to load: the successor mid-script, otherwise entry 0
    always_comb begin
        rd_addr = '0;
        if (state_q == StRun && cnt_q == '0 && !terminal) begin
            rd_addr = idx_q + AW'(1);
        end
    end

    // Next-state, counter and output-level logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
            ch_d    = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        cnt_d   = rd_wait;
                        idx_d   = rd_addr;
                        ch_d    = rd_level;
                        last_d  = rd_last;
                    end
                end
                StRun: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else if (!terminal || loop) begin
                        cnt_d  = rd_wait;
                        idx_d  = rd_addr;
                        ch_d   = rd_level;
                        last_d = rd_last;
                    end else begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign ch_out   = ch_q;
    assign step_idx = idx_q;
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);

endmodule
